// File: rtl/dma_bus_sched_pkg.sv
// Shared types for the MARIA bus-ownership scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_bus_sched_pkg;

    // Scheduler phases. The 3-bit encoding is shared with the debug readback path.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HALT_REQ = 3'd1,
        ST_SETUP    = 3'd2,
        ST_DMA      = 3'd3,
        ST_RELEASE  = 3'd4
    } sched_state_e;

    // ctrl[6:5] value that selects DMA mode; the parent decodes dma_en from it.
    localparam logic [1:0] CTRL_DMA_MODE = 2'b10;

endpackage

// File: rtl/dma_bus_sched_wsync_ready.sv
// CPU RDY flop for WSYNC: cleared by a WSYNC write, set again at hblank.
// Latency: ready_o changes on the edge after the pulse is sampled.
// Backpressure: none; pulses are single-cycle events and never stall.
//
// Ports:
//   pclk_2      system phase-2 clock
//   reset_b     asynchronous active-low reset (ready_o returns to 1)
//   deassert_i  WSYNC write pulse
//   hblank_i    first cycle of horizontal blank
//   ready_o     registered CPU RDY
module dma_bus_sched_wsync_ready (
    input  logic pclk_2,
    input  logic reset_b,
    input  logic deassert_i,
    input  logic hblank_i,
    output logic ready_o
);

    logic ready_q;
    logic ready_d;

    // Deassert takes priority: a WSYNC write landing on the hblank cycle
    // must still stall the CPU until the following line's hblank.
    always_comb begin
        ready_d = ready_q;
        if (deassert_i) begin
            ready_d = 1'b0;
        end else if (hblank_i) begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge pclk_2 or negedge reset_b) begin
        if (!reset_b) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;

endmodule

// File: rtl/dma_bus_sched.sv
// Bus-ownership scheduler between the 6502 and the MARIA DMA engine; also owns WSYNC RDY.
// Latency: all outputs registered, valid the cycle after the state transition edge.
// Backpressure: CPU write cycles hold the sequence in HALT_REQ indefinitely; DMA length set by dma_done.
//
// Ports:
//   pclk_2, reset_b       clock and asynchronous active-low reset
//   dma_en, dma_req       enable and request, sampled only in IDLE / HALT_REQ
//   dma_done              end-of-fetch pulse, honoured only in DMA
//   cpu_we_b              CPU R/W (1 = read); halt can only take effect on a read
//   deassert_ready        WSYNC write pulse
//   hblank_start          first cycle of horizontal blank
//   halt_b, ready         CPU HALT (active low) and RDY
//   drive_AB              MARIA owns the address bus
//   dma_active, dma_grant sequence-active level and DMA-entry pulse
//   dma_cycles            saturating DMA cycle count for the current line
module dma_bus_sched
    import dma_bus_sched_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int RELEASE_CYCLES = 1,
    parameter int CNT_W          = 9
) (
    input  logic             pclk_2,
    input  logic             reset_b,
    input  logic             dma_en,
    input  logic             dma_req,
    input  logic             dma_done,
    input  logic             cpu_we_b,
    input  logic             deassert_ready,
    input  logic             hblank_start,
    output logic             halt_b,
    output logic             ready,
    output logic             drive_AB,
    output logic             dma_active,
    output logic             dma_grant,
    output logic [CNT_W-1:0] dma_cycles
);

    // Counters are loaded with N-1 so the phase lasts exactly N cycles.
    localparam logic [3:0]       SETUP_LOAD   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]       RELEASE_LOAD = 4'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    sched_state_e     state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             halt_b_q, drive_ab_q, active_q, grant_q;
    logic             in_dma;

    assign in_dma = (state_q == ST_DMA);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_req && dma_en) begin
                    state_d = ST_HALT_REQ;
                end
            end
            ST_HALT_REQ: begin
                // Request withdrawn before the halt landed: back off cleanly.
                if (!(dma_req && dma_en)) begin
                    state_d = ST_IDLE;
                end else if (cpu_we_b) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DMA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DMA: begin
                if (dma_done) begin
                    state_d = ST_RELEASE;
                    cnt_d   = RELEASE_LOAD;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Line counter: hblank clears first, then the current DMA cycle still counts.
    always_comb begin
        dcnt_d = dcnt_q;
        if (hblank_start) begin
            dcnt_d = in_dma ? CNT_ONE : '0;
        end else if (in_dma && (dcnt_q != CNT_MAX)) begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge pclk_2 or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            dcnt_q     <= '0;
            halt_b_q   <= 1'b1;
            drive_ab_q <= 1'b0;
            active_q   <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            halt_b_q   <= (state_d == ST_IDLE);
            drive_ab_q <= (state_d == ST_DMA);
            active_q   <= (state_d inside {ST_SETUP, ST_DMA, ST_RELEASE});
            grant_q    <= (state_d == ST_DMA) && (state_q != ST_DMA);
        end
    end

    dma_bus_sched_wsync_ready u_wsync (
        .pclk_2     (pclk_2),
        .reset_b    (reset_b),
        .deassert_i (deassert_ready),
        .hblank_i   (hblank_start),
        .ready_o    (ready)
    );

    assign halt_b     = halt_b_q;
    assign drive_AB   = drive_ab_q;
    assign dma_active = active_q;
    assign dma_grant  = grant_q;
    assign dma_cycles = dcnt_q;

endmodule
